disp_arbiter: RTL
=================

# disp_arbiter

Arbitrates ownership of the 16-bit HEXS digit bus that feeds the 4-digit seven-segment display between three requesters, e.g. score, level and alert message. A round-robin grant is held for a guaranteed minimum dwell so each value stays readable. After the dwell the block rotates to the next pending requester. Sits directly upstream of the display scanner and drives its HEXS input from a registered output.

## Interface
- HOLD_CYCLES, 50_000_000, minimum dwell in clk cycles per grant (≥1)
- CNT_W, 26, dwell counter width (2^CNT_W ≥ HOLD_CYCLES)
- IDLE_PATTERN, 16'h0000, value on hexs when nobody owns the display

- clk  in  1  system clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- req  in  3  request per requester, level-sensitive
- data0  in  16  digit value of requester 0
- data1  in  16  digit value of requester 1
- data2  in  16  digit value of requester 2
- gnt  out  3  one-hot grant, 000 when idle
- hexs  out  16  registered value to display scanner
- valid  out  1  high while any grant active
- switch_pulse  out  1  one-cycle strobe on every change of gnt

## Operation
- States: IDLE, HOLD, OPEN. Round-robin pointer ptr (last owner).
- Winner selection is round-robin: first asserted req searching ptr+1, ptr+2, ptr (mod 3).
- IDLE:
  - Any req → grant winner, ptr←winner, cnt←0, → HOLD.
  - No req → stay.
- HOLD:
  - cnt increments each cycle.
  - Owner drops req → grant next winner if any other req (cnt←0, stay HOLD), else → IDLE.
  - cnt reaches HOLD_CYCLES-1 with owner still requesting → OPEN.
  - Other requests never preempt in HOLD.
- OPEN:
  - Any other req asserted → grant next winner, cnt←0, → HOLD.
  - Owner drops req with no other req → IDLE.
  - Otherwise keep owner indefinitely.
- hexs ← data of current owner every cycle, so a live value change is tracked. In IDLE hexs ← IDLE_PATTERN.
- valid = (gnt != 0). gnt is always one-hot or zero.
- switch_pulse is high for exactly one cycle whenever gnt changes, including a change to or from 000.
- Reset (RST=0, any time, asynchronous):
  - state IDLE, gnt=000, hexs=IDLE_PATTERN, valid=0, switch_pulse=0, cnt=0.
  - ptr=2, so requester 0 wins the first tie.
- Counter never wraps: it saturates in OPEN and is cleared on every grant.

## Timing
- req sampled at edge n → gnt, valid, switch_pulse and hexs (winner's data at n) valid after edge n+1; one-cycle arbitration latency.
- Data tracking latency while granted: 1 cycle.
- Dwell: a new owner granted at edge g keeps gnt through at least edge g+HOLD_CYCLES. Earliest handover is at edge g+HOLD_CYCLES+1 when a competitor was already requesting.
- HOLD_CYCLES=1: HOLD lasts one cycle.
- Owner drop is seen at edge n; the new gnt or IDLE takes effect after edge n+1. No cycle shows a stale owner's gnt with another owner's data.
- Simultaneous owner drop and cnt expiry: the drop takes priority.
- Release of RST is synchronous to clk by the caller. The first arbitration happens on the first edge with RST=1.

## Test plan
- Reset check with HOLD_CYCLES=4, IDLE_PATTERN=16'h0000: hold RST=0 with req=111 → gnt=000, hexs=0000, valid=0, switch_pulse=0. Assert RST=0 again mid-HOLD → all outputs return to reset values without a clock edge.
- Single requester: req=010, data1=16'h1234 at edge 0 → edge 1 gnt=010, hexs=1234, switch_pulse=1 for one cycle. data1→16'hABCD at edge 3 → hexs=ABCD at edge 4. Grant is held indefinitely.
- Tie then rotation: req=101 from reset, data0=16'h0001, data2=16'h0002:
  - edge 1: gnt=001, hexs=0001.
  - edge 6: gnt=100, hexs=0002.
  - edge 11: gnt=001.
  - switch_pulse at edges 1, 6 and 11.
- Early drop: requester 1 granted at edge 1, req1 drops at edge 2 with req2 pending → gnt=100 after edge 3. If nothing is pending → gnt=000, hexs=0000, valid=0 after edge 3.
- No preemption in HOLD: requester 0 granted at edge 1, req1 asserted at edge 2 → gnt stays 001 through edge 5, becomes 010 at edge 6.
- Round-robin fairness: all three req held high for 40 cycles → grant order 0,1,2,0,… with every grant lasting exactly 5 cycles and gnt always one-hot.

Source files
------------

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - round-robin owner of the HEXS digit bus with a guaranteed minimum dwell per grant
module disp_arbiter #(
    parameter int          HOLD_CYCLES  = 50_000_000,
    parameter int          CNT_W        = 26,
    parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  gnt,
    output logic [15:0] hexs,
    output logic        valid,
    output logic        switch_pulse
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_OPEN = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_gnt;
    logic [15:0]      r_hexs;
    logic             r_switch;

    logic [1:0]       w_i1;
    logic [1:0]       w_i2;
    logic [1:0]       w_win_idx;
    logic             w_win_hit;
    logic [2:0]       w_win_gnt;
    logic             w_own_req;
    logic             w_other_req;

    logic [1:0]       w_state_nx;
    logic [1:0]       w_ptr_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [2:0]       w_gnt_nx;
    logic [15:0]      w_hexs_nx;

    // Search order ptr+1, ptr+2, ptr: the last owner only wins when nobody else asks.
    always_comb begin
        w_i1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
        w_i2 = (w_i1 == 2'd2) ? 2'd0 : w_i1 + 2'd1;
        w_win_hit = 1'b1;
        w_win_idx = r_ptr;
        if (req[w_i1]) begin
            w_win_idx = w_i1;
        end else if (req[w_i2]) begin
            w_win_idx = w_i2;
        end else if (req[r_ptr]) begin
            w_win_idx = r_ptr;
        end else begin
            w_win_hit = 1'b0;
        end
        w_win_gnt   = 3'b001 << w_win_idx;
        w_own_req   = |(req & r_gnt);
        w_other_req = |(req & ~r_gnt);
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_cnt_nx   = r_cnt;
        w_gnt_nx   = r_gnt;
        case (r_state)
            ST_IDLE: begin
                if (w_win_hit) begin
                    w_state_nx = ST_HOLD;
                    w_ptr_nx   = w_win_idx;
                    w_cnt_nx   = '0;
                    w_gnt_nx   = w_win_gnt;
                end
            end
            ST_HOLD: begin
                // An owner drop beats dwell expiry landing on the same edge.
                if (!w_own_req) begin
                    if (w_win_hit) begin
                        w_ptr_nx = w_win_idx;
                        w_cnt_nx = '0;
                        w_gnt_nx = w_win_gnt;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                        w_gnt_nx   = 3'b000;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nx = ST_OPEN;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_OPEN: begin
                if (w_other_req) begin
                    w_state_nx = ST_HOLD;
                    w_ptr_nx   = w_win_idx;
                    w_cnt_nx   = '0;
                    w_gnt_nx   = w_win_gnt;
                end else if (!w_own_req) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_gnt_nx   = 3'b000;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_gnt_nx   = 3'b000;
            end
        endcase
    end

    // Data follows the next grant so gnt and hexs always change on the same edge.
    always_comb begin
        case (w_gnt_nx)
            3'b001:  w_hexs_nx = data0;
            3'b010:  w_hexs_nx = data1;
            3'b100:  w_hexs_nx = data2;
            default: w_hexs_nx = IDLE_PATTERN;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_ptr    <= 2'd2;
            r_cnt    <= '0;
            r_gnt    <= 3'b000;
            r_hexs   <= IDLE_PATTERN;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_ptr    <= w_ptr_nx;
            r_cnt    <= w_cnt_nx;
            r_gnt    <= w_gnt_nx;
            r_hexs   <= w_hexs_nx;
            r_switch <= (w_gnt_nx != r_gnt);
        end
    end

    assign gnt          = r_gnt;
    assign hexs         = r_hexs;
    assign valid        = |r_gnt;
    assign switch_pulse = r_switch;

endmodule
